// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage.
//   pwm_state_t : timebase FSM encoding (IDLE = 1'b0, RUN = 1'b1)
//   PWM_CNT_W   : width of the PWM period counter
//   PWM_CNT_MAX : last counter value before wrap
//   DUTY_FULL   : duty value that means "always high"
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int                   PWM_CNT_W   = 8;
    localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL   = 8'hFF;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, IDLE/RUN FSM and the
// period-aligned duty shadow register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no pin in PWM mode; prescaler/cnt held at 0, duty tracked
// RUN   | counting; duty shadow reloaded only at the period wrap
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   en_pwm_any     : at least one pin selects PWM mode
//   pwm_duty_cycle : requested duty (unshadowed)
//   cnt            : current PWM counter value
//   duty_shadow    : duty value in effect for the current period
//   period_start   : one-clk pulse aligned with the first cnt==0 cycle
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_pwm_any,
    input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
    output logic [PWM_CNT_W-1:0] cnt,
    output logic [PWM_CNT_W-1:0] duty_shadow,
    output logic                 period_start
);

    localparam int                 PRESC_W    = $clog2(CLK_DIV + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    pwm_state_t         state;
    pwm_state_t         state_nxt;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               wrap;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_pwm_any)  state_nxt = RUN;
            RUN:     if (!en_pwm_any) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / decode logic. The prescaler sits at 0 in IDLE, which would
    // look like a tick when CLK_DIV==1, so tick is qualified with RUN.
    always_comb begin
        tick = 1'b0;
        wrap = 1'b0;
        if (state == RUN) begin
            tick = (presc == PRESC_LAST);
            wrap = tick && (cnt == PWM_CNT_MAX);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            duty_shadow  <= '0;
            period_start <= 1'b0;
        end else begin
            // Depends only on pre-edge state, so it still pulses when
            // PWM mode is dropped on the wrap edge.
            period_start <= wrap;
            if (state == IDLE) begin
                presc       <= '0;
                cnt         <= '0;
                duty_shadow <= pwm_duty_cycle;
            end else begin
                if (wrap) begin
                    duty_shadow <= pwm_duty_cycle;
                end
                if (!en_pwm_any) begin
                    presc <= '0;
                    cnt   <= '0;
                end else if (tick) begin
                    presc <= '0;
                    cnt   <= cnt + PWM_CNT_W'(1);
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: drives 16 user pins from the SPI register outputs.
// Each pin is low (output disabled), static high (enabled, not PWM) or
// follows the shared PWM waveform. Pin drive is registered.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   en_reg_out_7_0/15_8 : output enables, pins 7..0 / 15..8
//   en_reg_pwm_7_0/15_8 : PWM-mode selects, pins 7..0 / 15..8
//   pwm_duty_cycle      : requested duty 0x00..0xFF
//   out                 : pin drive, bit i = pin i
//   period_start        : one-clk pulse at each PWM period wrap
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic [15:0]          en_out;
    logic [15:0]          en_pwm;
    logic [PWM_CNT_W-1:0] cnt;
    logic [PWM_CNT_W-1:0] duty_shadow;
    logic                 pwm_level;
    logic [15:0]          out_nxt;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_pwm_any     (|en_pwm),
        .pwm_duty_cycle (pwm_duty_cycle),
        .cnt            (cnt),
        .duty_shadow    (duty_shadow),
        .period_start   (period_start)
    );

    // Full-scale duty is forced high so 0xFF means 100%, not 255/256.
    assign pwm_level = (duty_shadow == DUTY_FULL) || (cnt < duty_shadow);

    always_comb begin
        out_nxt = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= 16'h0000;
        end else begin
            out <= out_nxt;
        end
    end

endmodule
